// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: segment patterns (active-high, bit6=a .. bit0=g),
// blank pattern, scan-decoder FSM state type and anode-code helper.
package sevenseg_pkg;

   localparam logic [6:0] SEG_0     = 7'h7E;
   localparam logic [6:0] SEG_1     = 7'h30;
   localparam logic [6:0] SEG_2     = 7'h6D;
   localparam logic [6:0] SEG_3     = 7'h79;
   localparam logic [6:0] SEG_4     = 7'h33;
   localparam logic [6:0] SEG_5     = 7'h5B;
   localparam logic [6:0] SEG_6     = 7'h5F;
   localparam logic [6:0] SEG_7     = 7'h70;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h7B;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h1F;
   localparam logic [6:0] SEG_C     = 7'h0D;
   localparam logic [6:0] SEG_D     = 7'h3D;
   localparam logic [6:0] SEG_E     = 7'h4F;
   localparam logic [6:0] SEG_F     = 7'h47;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic {
      WAIT_STABLE,
      CAPTURED
   } scan_state_t;

   // True when exactly one active-low anode is driven
   function automatic logic an_one_low(input logic [3:0] an);
      return (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
   endfunction

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational seven-segment pattern to hex nibble decoder.
module sevenseg_pattern_decode
   import sevenseg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic       hit,
   output logic       blank,
   output logic [3:0] nibble
);

   // Table lookup of the active-high pattern; blank is reported separately
   always_comb begin
      hit    = 1'b1;
      nibble = 4'h0;
      blank  = (pattern == SEG_BLANK);
      case (pattern)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: hit    = 1'b0;
      endcase
   end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit seven-segment scan.
// Captures each scan slot once after SETTLE_CYCLES of stable inputs.
// Optional macro SEVSEG_DP_CAPTURE_EN adds decimal-point capture (dp_n in, dp out).
module sevenseg_scan_decoder
   import sevenseg_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg_n,
   input  logic [3:0]  an_n,
`ifdef SEVSEG_DP_CAPTURE_EN
   input  logic        dp_n,
   output logic [3:0]  dp,
`endif
   output logic [15:0] digits,
   output logic [3:0]  digit_valid,
   output logic [3:0]  digit_blank,
   output logic [3:0]  pattern_err,
   output logic        an_err,
   output logic        frame_done
);

   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_FIRE  = CNT_W'(SETTLE_CYCLES - 1);

   logic [6:0]       seg_q;
   logic [3:0]       an_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   scan_state_t      state_q, state_d;
   logic [15:0]      digits_q, digits_d;
   logic [3:0]       valid_q, valid_d;
   logic [3:0]       blank_q, blank_d;
   logic [3:0]       perr_q, perr_d;
   logic [3:0]       seen_q, seen_d;
   logic             an_err_q, an_err_d;
   logic             fd_q, fd_d;
   logic             changed, capture;
   logic             dec_hit, dec_blank;
   logic [3:0]       dec_nibble;

`ifdef SEVSEG_DP_CAPTURE_EN
   logic             dp_in_q;
   logic [3:0]       dp_q, dp_d;
   assign changed = ({dp_n, an_n, seg_n} != {dp_in_q, an_q, seg_q});
   assign dp      = dp_q;
`else
   assign changed = ({an_n, seg_n} != {an_q, seg_q});
`endif

   assign capture = (state_q == WAIT_STABLE) && !changed && (cnt_q == CNT_FIRE);

   sevenseg_pattern_decode u_decode (
      .pattern (~seg_q),
      .hit     (dec_hit),
      .blank   (dec_blank),
      .nibble  (dec_nibble)
   );

   // Next-state: settle counter, window FSM, capture action and frame tracking
   always_comb begin
      cnt_d    = cnt_q;
      state_d  = state_q;
      digits_d = digits_q;
      valid_d  = valid_q;
      blank_d  = blank_q;
      perr_d   = perr_q;
      seen_d   = seen_q;
      an_err_d = an_err_q;
`ifdef SEVSEG_DP_CAPTURE_EN
      dp_d     = dp_q;
`endif

      if (changed) begin
         cnt_d   = '0;
         state_d = WAIT_STABLE;
      end else begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
         if (capture) state_d = CAPTURED;
      end

      // A full seen mask pulses frame_done and restarts tracking; a capture on
      // that same edge still counts toward the next frame.
      fd_d = (seen_q == 4'hF);
      if (fd_d) seen_d = '0;

      if (capture) begin
         if (an_one_low(an_q)) begin
            for (int unsigned i = 0; i < 4; i++) begin
               if (!an_q[i]) begin
                  seen_d[i]  = 1'b1;
                  valid_d[i] = dec_hit;
                  blank_d[i] = dec_blank;
                  perr_d[i]  = !dec_hit && !dec_blank;
                  if (dec_hit) digits_d[i*4 +: 4] = dec_nibble;
`ifdef SEVSEG_DP_CAPTURE_EN
                  dp_d[i] = ~dp_in_q;
`endif
               end
            end
         end else begin
            an_err_d = 1'b1;
         end
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q    <= '1;
         an_q     <= '1;
         cnt_q    <= '0;
         state_q  <= WAIT_STABLE;
         digits_q <= '0;
         valid_q  <= '0;
         blank_q  <= '0;
         perr_q   <= '0;
         seen_q   <= '0;
         an_err_q <= 1'b0;
         fd_q     <= 1'b0;
`ifdef SEVSEG_DP_CAPTURE_EN
         dp_in_q  <= 1'b1;
         dp_q     <= '0;
`endif
      end else begin
         seg_q    <= seg_n;
         an_q     <= an_n;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         digits_q <= digits_d;
         valid_q  <= valid_d;
         blank_q  <= blank_d;
         perr_q   <= perr_d;
         seen_q   <= seen_d;
         an_err_q <= an_err_d;
         fd_q     <= fd_d;
`ifdef SEVSEG_DP_CAPTURE_EN
         dp_in_q  <= dp_n;
         dp_q     <= dp_d;
`endif
      end
   end

   assign digits      = digits_q;
   assign digit_valid = valid_q;
   assign digit_blank = blank_q;
   assign pattern_err = perr_q;
   assign an_err      = an_err_q;
   assign frame_done  = fd_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Bench for sevenseg_scan_decoder: two instances (SETTLE_CYCLES=4 and 1) driven
// with the same scan lines, checked every cycle against a window-length model.
module tb_sevenseg_scan_decoder;

   logic clk = 1'b0;
   logic rst;
   logic [6:0] seg_n;
   logic [3:0] an_n;
   always #5 clk = ~clk;

   logic [1:0][15:0] dig_a;
   logic [1:0][3:0]  val_a, blk_a, err_a;
   logic [1:0]       anerr_a, fd_a;
`ifdef SEVSEG_DP_CAPTURE_EN
   logic             dp_n;
   logic [1:0][3:0]  dp_a;
   logic [1:0][3:0]  m_dp;
`endif

   sevenseg_scan_decoder #(.SETTLE_CYCLES(4), .CNT_W(8)) u0 (
      .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
`ifdef SEVSEG_DP_CAPTURE_EN
      .dp_n(dp_n), .dp(dp_a[0]),
`endif
      .digits(dig_a[0]), .digit_valid(val_a[0]), .digit_blank(blk_a[0]),
      .pattern_err(err_a[0]), .an_err(anerr_a[0]), .frame_done(fd_a[0]));

   sevenseg_scan_decoder #(.SETTLE_CYCLES(1), .CNT_W(8)) u1 (
      .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
`ifdef SEVSEG_DP_CAPTURE_EN
      .dp_n(dp_n), .dp(dp_a[1]),
`endif
      .digits(dig_a[1]), .digit_valid(val_a[1]), .digit_blank(blk_a[1]),
      .pattern_err(err_a[1]), .an_err(anerr_a[1]), .frame_done(fd_a[1]));

   int n_cmp = 0;
   int n_bad = 0;
   int fd_cnt = 0;
   logic chk_en = 1'b0;

   logic [6:0] pats [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h0D, 7'h3D, 7'h4F, 7'h47};

   function automatic int settle_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic int lookup(input logic [6:0] p);
      for (int k = 0; k < 16; k++) if (pats[k] == p) return k;
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: capture when the sampled inputs have been identical for exactly S edges
   int               run [2];
   logic [11:0]      prev [2];
   logic [1:0][15:0] m_dig;
   logic [1:0][3:0]  m_val, m_blk, m_err, m_seen;
   logic [1:0]       m_anerr, m_fd;

   always @(posedge clk) begin
      logic [11:0] cur;
      logic [6:0]  p;
      int nz, d, idx;
`ifdef SEVSEG_DP_CAPTURE_EN
      cur = {dp_n, an_n, seg_n};
`else
      cur = {1'b1, an_n, seg_n};
`endif
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            run[i] = 0; prev[i] = 12'hFFF;
            m_dig[i] = '0; m_val[i] = '0; m_blk[i] = '0; m_err[i] = '0;
            m_seen[i] = '0; m_anerr[i] = 1'b0; m_fd[i] = 1'b0;
`ifdef SEVSEG_DP_CAPTURE_EN
            m_dp[i] = '0;
`endif
         end else begin
            if (cur == prev[i]) run[i]++; else run[i] = 0;
            prev[i] = cur;
            m_fd[i] = (m_seen[i] == 4'hF);
            if (m_fd[i]) m_seen[i] = '0;
            if (run[i] == settle_of(i)) begin
               nz = 0; d = 0;
               for (int b = 0; b < 4; b++) if (!an_n[b]) begin nz++; d = b; end
               if (nz != 1) m_anerr[i] = 1'b1;
               else begin
                  p = ~seg_n;
                  idx = lookup(p);
                  m_seen[i][d] = 1'b1;
                  m_val[i][d] = (idx >= 0);
                  m_blk[i][d] = (p == 7'h00);
                  m_err[i][d] = (idx < 0) && (p != 7'h00);
                  if (idx >= 0) m_dig[i][d*4 +: 4] = idx[3:0];
`ifdef SEVSEG_DP_CAPTURE_EN
                  m_dp[i][d] = ~dp_n;
`endif
               end
            end
         end
      end
   end

   // Per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         if (fd_a[0]) fd_cnt++;
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.digits", i), 32'(dig_a[i]), 32'(m_dig[i]));
            chk($sformatf("u%0d.valid", i), 32'(val_a[i]), 32'(m_val[i]));
            chk($sformatf("u%0d.blank", i), 32'(blk_a[i]), 32'(m_blk[i]));
            chk($sformatf("u%0d.pattern_err", i), 32'(err_a[i]), 32'(m_err[i]));
            chk($sformatf("u%0d.an_err", i), 32'(anerr_a[i]), 32'(m_anerr[i]));
            chk($sformatf("u%0d.frame_done", i), 32'(fd_a[i]), 32'(m_fd[i]));
`ifdef SEVSEG_DP_CAPTURE_EN
            chk($sformatf("u%0d.dp", i), 32'(dp_a[i]), 32'(m_dp[i]));
`endif
         end
      end
   end

   task automatic apply(input logic [3:0] a, input logic [6:0] pat);
      @(posedge clk); #2;
      an_n = a;
      seg_n = ~pat;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk); #1;
   endtask

   initial begin
      int fd0, hold, r;
      logic [3:0] a;
      logic [6:0] pat;
      logic [6:0] scan_pats [4];
      scan_pats = '{7'h30, 7'h79, 7'h47, 7'h47};
      rst = 1'b1; an_n = 4'hF; seg_n = 7'h7F;
`ifdef SEVSEG_DP_CAPTURE_EN
      dp_n = 1'b1;
`endif
      @(posedge clk); #1 chk_en = 1'b1;
      wait_cyc(2);
      chk("rst.digits", 32'(dig_a[0]), 32'h0);
      chk("rst.valid", 32'(val_a[0]), 32'h0);
      chk("rst.an_err", 32'(anerr_a[0]), 32'h0);

      // First capture needs the full settle window
      @(posedge clk); #2;
      rst = 1'b0; an_n = 4'b1110; seg_n = ~7'h7E;
      wait_cyc(4);
      chk("lat.before_edge4", 32'(val_a[0]), 32'h0);
      wait_cyc(1);
      chk("lat.edge4_valid", 32'(val_a[0]), 32'h1);
      chk("lat.edge4_digit0", 32'(dig_a[0][3:0]), 32'h0);
      chk("lat.no_frame", 32'(fd_cnt), 32'd0);

      // Never-stable slot, then a settled 5
      for (int i = 0; i < 10; i++) begin
         apply(4'b1101, (i % 2 == 1) ? 7'h79 : 7'h30);
         @(posedge clk);
      end
      wait_cyc(0);
      chk("toggle.valid1", 32'(val_a[0][1]), 32'h0);
      apply(4'b1101, 7'h5B);
      wait_cyc(6);
      chk("settled.digit1", 32'(dig_a[0][7:4]), 32'h5);

      // Full scan
      fd0 = fd_cnt;
      for (int d = 0; d < 4; d++) begin
         a = ~(4'b0001 << d);
         apply(a, scan_pats[d]);
         wait_cyc(2047);
      end
      chk("scan.digits", 32'(dig_a[0]), 32'hFF31);
      chk("scan.valid", 32'(val_a[0]), 32'hF);
      chk("scan.one_pulse", 32'(fd_cnt - fd0), 32'd1);
      for (int d = 0; d < 3; d++) begin
         a = ~(4'b0001 << d);
         apply(a, scan_pats[d]);
         wait_cyc(8);
      end
      chk("rescan.no_pulse", 32'(fd_cnt - fd0), 32'd1);
      apply(4'b0111, 7'h47);
      wait_cyc(8);
      chk("rescan.pulse", 32'(fd_cnt - fd0), 32'd2);

      // Blank and illegal pattern on digit 2
      apply(4'b1011, 7'h00);
      wait_cyc(8);
      chk("blank.blank2", 32'(blk_a[0][2]), 32'h1);
      chk("blank.valid2", 32'(val_a[0][2]), 32'h0);
      apply(4'b1011, 7'h7C);
      wait_cyc(8);
      chk("illegal.err2", 32'(err_a[0][2]), 32'h1);
      chk("illegal.digit2", 32'(dig_a[0][11:8]), 32'hF);

      // Illegal anode code, then reset mid-window
      apply(4'b1111, 7'h7E);
      wait_cyc(8);
      chk("anode.an_err", 32'(anerr_a[0]), 32'h1);
      chk("anode.digits", 32'(dig_a[0]), 32'hFF31);
      apply(4'b1110, 7'h30);
      wait_cyc(2);
      @(posedge clk); #2 rst = 1'b1;
      wait_cyc(1);
      chk("midrst.digits", 32'(dig_a[0]), 32'h0);
      chk("midrst.an_err", 32'(anerr_a[0]), 32'h0);
      chk("midrst.valid", 32'(val_a[0]), 32'h0);
      @(posedge clk); #2 rst = 1'b0;

`ifdef SEVSEG_DP_CAPTURE_EN
      @(posedge clk); #2 dp_n = 1'b0;
      apply(4'b0111, 7'h4F);
      wait_cyc(6);
      chk("dp.digit3", 32'(dig_a[0][15:12]), 32'hE);
      chk("dp.dp", 32'(dp_a[0]), 32'h8);
`endif

      // Randomized scan windows
      for (int w = 0; w < 500; w++) begin
         hold = int'($urandom_range(1, 8));
         r = int'($urandom_range(0, 9));
         if (r < 8) a = ~(4'b0001 << (r % 4));
         else a = 4'($urandom);
         r = int'($urandom_range(0, 19));
         if (r < 15) pat = pats[$urandom_range(0, 15)];
         else if (r < 17) pat = 7'h00;
         else pat = 7'($urandom);
         @(posedge clk); #2;
         an_n = a; seg_n = ~pat;
         rst = ($urandom_range(0, 59) == 0);
`ifdef SEVSEG_DP_CAPTURE_EN
         dp_n = 1'($urandom);
`endif
         repeat (hold - 1) begin
            @(posedge clk); #2 rst = 1'b0;
         end
         if (hold == 1) begin
            @(posedge clk); #2 rst = 1'b0;
         end
      end
      wait_cyc(10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sevenseg_scan_decoder.md
Name: sevenseg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 4-digit seven-segment driver.
- Watches the active-low segment and anode scan lines, waits for each scan slot to settle, and decodes the segment pattern back into a hex nibble per digit.
- Flags blank digits, illegal patterns and illegal anode codes.
- Used as an on-chip loopback monitor and as a bench checker for display drivers.

Parameters:
- SETTLE_CYCLES, 4: consecutive cycles {an_n, seg_n} must be unchanged before capture; legal range 1..255.
- CNT_W, 8: width of the settle counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- seg_n  in  7  segments, active-low; bit6=a … bit0=g
- an_n  in  4  digit anodes, active-low; bit0=digit0
- digits  out  16  decoded nibbles; [3:0]=digit0 … [15:12]=digit3
- digit_valid  out  4  digit holds a legal decoded value
- digit_blank  out  4  last capture for that digit was all segments off
- pattern_err  out  4  last capture for that digit was an unrecognised pattern
- an_err  out  1  sticky; set on a stable illegal anode code
- frame_done  out  1  one-cycle pulse when all 4 digits have been captured since the previous pulse

Behaviour:
- Input stage: seg_n and an_n are registered every cycle into seg_q and an_q. All logic uses the registered copies.
- Settle counter:
  - If {an_n, seg_n} differs from {an_q, seg_q}, cnt <= 0.
  - Otherwise cnt increments, saturating at SETTLE_CYCLES.
- FSM states: WAIT_STABLE, CAPTURED.
  - WAIT_STABLE -> CAPTURED when cnt == SETTLE_CYCLES-1 and inputs are still unchanged. The capture action fires on that edge.
  - CAPTURED -> WAIT_STABLE on any input change.
  - Result: exactly one capture per stable window, however long the window lasts.
- Timing: if the inputs are constant from sampling edge k onward, outputs update at edge k+SETTLE_CYCLES.
- Capture action, selected digit d = the index of the single zero bit in an_q:
  - Decode p = ~seg_q (active-high) using this table:
    - 0:7E, 1:30, 2:6D, 3:79, 4:33, 5:5B, 6:5F, 7:70
    - 8:7F, 9:7B, A:77, b:1F, c:0D, d:3D, E:4F, F:47
  - Table hit: digits[d] <= nibble, valid=1, blank=0, err=0.
  - p == 00: digits[d] unchanged, valid=0, blank=1, err=0.
  - Any other p: digits[d] unchanged, valid=0, blank=0, err=1.
  - Set seen[d].
- Illegal anode code (an_q not exactly one zero bit, e.g. 1111 or 1100) at the capture point:
  - No digit update and seen is unchanged.
  - an_err <= 1; it stays set until rst.
- frame_done:
  - When seen becomes 1111, pulse frame_done high for 1 cycle the following cycle and clear seen to 0000 in the same cycle.
  - Re-capturing an already-seen digit does not pulse.
- Digit order is free: any scan order and any repeats are accepted.
- Reset (synchronous, any point mid-window):
  - digits=0, digit_valid=0, digit_blank=0, pattern_err=0, an_err=0, frame_done=0, seen=0, cnt=0.
  - seg_q and an_q reset to all ones; state=WAIT_STABLE.
  - The first capture after reset needs a full settle window.
- SETTLE_CYCLES=1: capture on the first cycle the inputs match their registered copy.

Optional Feature:
- Macro SEVSEG_DP_CAPTURE_EN.
- Defined:
  - Adds input dp_n (1 bit, active-low) and output dp (4 bits).
  - dp_n joins the stability comparison.
  - On a legal-anode capture, dp[d] <= ~dp_n.
  - dp resets to 0000.
- Undefined: no dp_n/dp ports, and the decimal point is ignored entirely.

Decomposition:
- Package sevenseg_pkg holds:
  - the 16 segment pattern constants (SEG_0..SEG_F, shared with the driver side);
  - SEG_BLANK = 7'h00;
  - the FSM state typedef.
- Sub-module sevenseg_pattern_decode: purely combinational 7-bit pattern -> {hit, blank, nibble}. The top module holds the counter, FSM and digit registers.

Test Plan (SETTLE_CYCLES=4):
- After reset, drive an_n=1110, seg_n=~7E for 4 cycles -> at edge 4, digits[3:0]=0, digit_valid=0001; no frame_done.
- Toggle seg_n every 2 cycles with an_n=1101 (never stable for 4) -> no update to digit1; a later stable 4 cycles of ~5B gives digits[7:4]=5.
- Scan digits 0..3 with patterns 30, 79, 47, 47 (~ applied), 2048 cycles each -> digits=16'hFF31, valid=1111, exactly one frame_done pulse after digit3; no further pulse until all four are recaptured.
- Stable an_n=1011 with seg_n=~00 -> blank[2]=1, valid[2]=0. Then ~7C (illegal) -> pattern_err[2]=1 and digits[11:8] unchanged.
- Stable an_n=1111 for 4 cycles -> an_err=1 and no digit change. Assert rst mid-window -> all outputs 0 next cycle and an_err cleared.
- With SEVSEG_DP_CAPTURE_EN: an_n=0111, seg_n=~4F, dp_n=0 -> digits[15:12]=E, dp=1000.
